// File: rtl/rv32i_pkg.sv
// Shared RV32I pipeline definitions: bubble encoding, default reset PC and
// the instruction-fetch FSM state encoding.
package rv32i_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;

    typedef enum logic [1:0] {
        REQ   = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, keeps one imem request outstanding and
// feeds a registered {instr, pc, pc+4, valid} bundle to the IF/ID register.
module if_fetch_unit #(
    parameter int unsigned      WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_PC  = WIDTH'(rv32i_pkg::RESET_PC),
    parameter logic [WIDTH-1:0] NOP_INSTR = WIDTH'(rv32i_pkg::NOP_INSTR)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall_i,
    input  logic             redirect_i,
    input  logic [WIDTH-1:0] redirect_pc_i,
    output logic             imem_req_o,
    output logic [WIDTH-1:0] imem_addr_o,
    input  logic             imem_rvalid_i,
    input  logic [WIDTH-1:0] imem_rdata_i,
    output logic [WIDTH-1:0] instr_o,
    output logic [WIDTH-1:0] pc_o,
    output logic [WIDTH-1:0] pc4_o,
    output logic             instr_valid_o
);

    import rv32i_pkg::fetch_state_t;
    import rv32i_pkg::REQ;
    import rv32i_pkg::WAIT;
    import rv32i_pkg::DRAIN;

    localparam logic [WIDTH-1:0] PC_STEP = {{(WIDTH-3){1'b0}}, 3'd4};

    fetch_state_t     state_r;
    fetch_state_t     state_nxt_s;
    logic [WIDTH-1:0] pc_r;
    logic [WIDTH-1:0] pc_nxt_s;
    logic [WIDTH-1:0] req_pc_r;
    logic [WIDTH-1:0] req_pc_nxt_s;
    logic [WIDTH-1:0] instr_r;
    logic [WIDTH-1:0] instr_nxt_s;
    logic [WIDTH-1:0] out_pc_r;
    logic [WIDTH-1:0] out_pc_nxt_s;
    logic [WIDTH-1:0] out_pc4_r;
    logic [WIDTH-1:0] out_pc4_nxt_s;
    logic             valid_r;
    logic             valid_nxt_s;
    logic             req_fire_s;
    logic             capture_s;
    logic             consume_s;
    logic [WIDTH-1:0] redirect_tgt_s;
    logic             unused_redirect_low_s;

    assign redirect_tgt_s        = {redirect_pc_i[WIDTH-1:2], 2'b00};
    assign unused_redirect_low_s = ^redirect_pc_i[1:0];

    assign imem_req_o    = req_fire_s;
    assign imem_addr_o   = pc_r;
    assign instr_o       = instr_r;
    assign pc_o          = out_pc_r;
    assign pc4_o         = out_pc4_r;
    assign instr_valid_o = valid_r;

    // Request strobe and the per-cycle capture/consume events.
    always_comb begin
        req_fire_s = 1'b0;
        capture_s  = 1'b0;
        consume_s  = 1'b0;
        // Requests may only issue once the output slot is free or draining this edge.
        if (!reset && (state_r == REQ) && !redirect_i && (!valid_r || !stall_i)) begin
            req_fire_s = 1'b1;
        end else begin
            req_fire_s = 1'b0;
        end
        if ((state_r == WAIT) && imem_rvalid_i) begin
            capture_s = 1'b1;
        end else begin
            capture_s = 1'b0;
        end
        if (valid_r && !stall_i) begin
            consume_s = 1'b1;
        end else begin
            consume_s = 1'b0;
        end
    end

    // Next state; a redirect with a response in flight must drain it first.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            REQ: begin
                if (redirect_i) begin
                    state_nxt_s = REQ;
                end else if (req_fire_s) begin
                    state_nxt_s = WAIT;
                end else begin
                    state_nxt_s = REQ;
                end
            end
            WAIT: begin
                if (redirect_i) begin
                    state_nxt_s = imem_rvalid_i ? REQ : DRAIN;
                end else if (imem_rvalid_i) begin
                    state_nxt_s = REQ;
                end else begin
                    state_nxt_s = WAIT;
                end
            end
            DRAIN: begin
                if (imem_rvalid_i) begin
                    state_nxt_s = REQ;
                end else begin
                    state_nxt_s = DRAIN;
                end
            end
            default: begin
                state_nxt_s = REQ;
            end
        endcase
    end

    // Fetch PC and in-flight address; redirect overrides any increment.
    always_comb begin
        pc_nxt_s     = pc_r;
        req_pc_nxt_s = req_pc_r;
        if (redirect_i) begin
            pc_nxt_s = redirect_tgt_s;
        end else if (req_fire_s) begin
            pc_nxt_s = pc_r + PC_STEP;
        end else begin
            pc_nxt_s = pc_r;
        end
        if (req_fire_s) begin
            req_pc_nxt_s = pc_r;
        end else begin
            req_pc_nxt_s = req_pc_r;
        end
    end

    // Output register: flush on redirect, load on capture, bubble after consume.
    always_comb begin
        instr_nxt_s   = instr_r;
        out_pc_nxt_s  = out_pc_r;
        out_pc4_nxt_s = out_pc4_r;
        valid_nxt_s   = valid_r;
        if (redirect_i) begin
            instr_nxt_s = NOP_INSTR;
            valid_nxt_s = 1'b0;
        end else if (capture_s) begin
            instr_nxt_s   = imem_rdata_i;
            out_pc_nxt_s  = req_pc_r;
            out_pc4_nxt_s = req_pc_r + PC_STEP;
            valid_nxt_s   = 1'b1;
        end else if (consume_s) begin
            instr_nxt_s = NOP_INSTR;
            valid_nxt_s = 1'b0;
        end else begin
            valid_nxt_s = valid_r;
        end
    end

    // State, PC and output register storage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= REQ;
            pc_r      <= RESET_PC;
            req_pc_r  <= {WIDTH{1'b0}};
            instr_r   <= NOP_INSTR;
            out_pc_r  <= {WIDTH{1'b0}};
            out_pc4_r <= {WIDTH{1'b0}};
            valid_r   <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            pc_r      <= pc_nxt_s;
            req_pc_r  <= req_pc_nxt_s;
            instr_r   <= instr_nxt_s;
            out_pc_r  <= out_pc_nxt_s;
            out_pc4_r <= out_pc4_nxt_s;
            valid_r   <= valid_nxt_s;
        end
    end

endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction-fetch stage of the 5-stage RV32I pipeline. Owns the program counter, issues one-outstanding-request fetches to instruction memory, and presents `{instr, pc, pc+4}` to the IF/ID pipeline register directly downstream. Handles hazard-unit stalls and EX-stage branch/jump redirects, discarding wrong-path data. Drives a NOP bubble whenever no valid instruction is available.

## Interface
- `WIDTH`, 32, data/address width
- `RESET_PC`, 32'h0000_0000, first fetch address after reset
- `NOP_INSTR`, 32'h0000_0013, bubble encoding (`addi x0,x0,0`)

Ports:
- `clk` in 1: clock
- `reset` in 1: reset, asynchronous, active-high
- `stall_i` in 1: hazard-unit stall; IF/ID holds this cycle
- `redirect_i` in 1: taken branch/jump from EX; same cycle as IF/ID flush
- `redirect_pc_i` in WIDTH: redirect target
- `imem_req_o` out 1: fetch request strike, one cycle per request
- `imem_addr_o` out WIDTH: fetch address, word-aligned
- `imem_rvalid_i` in 1: response valid
- `imem_rdata_i` in WIDTH: response instruction word
- `instr_o` out WIDTH: to IF/ID `Instr`
- `pc_o` out WIDTH: to IF/ID `PC_in`
- `pc4_o` out WIDTH: to IF/ID `PC4_in`
- `instr_valid_o` out 1: output register holds a real instruction

## Operation
- Registers: `pc_q` (next fetch address), `req_pc_q` (address in flight), `state_q`, output register `{instr_o, pc_o, pc4_o, instr_valid_o}`.
- Consume event: `instr_valid_o && !stall_i` at a clock edge. The output register clears `instr_valid_o` on that edge and drives `instr_o = NOP_INSTR`.
- States:
  - REQ: `imem_req_o = !redirect_i && (!instr_valid_o || !stall_i)`. When the request fires: `req_pc_q <= pc_q`, `pc_q <= pc_q + 4`, go to WAIT.
  - WAIT: on `imem_rvalid_i`, load the output register with `instr_o = rdata`, `pc_o = req_pc_q`, `pc4_o = req_pc_q + 4`, valid=1, then go to REQ. The register is always empty here because only one request is outstanding.
  - DRAIN: an outstanding response is wrong-path. On `imem_rvalid_i`, drop the data and go to REQ.
- Redirect (priority over stall and over everything else):
  - `pc_q <= {redirect_pc_i[WIDTH-1:2], 2'b00}` (low bits forced zero).
  - `instr_valid_o <= 0`, `instr_o <= NOP_INSTR`.
  - From REQ: no request that cycle; stay REQ.
  - From WAIT: go to DRAIN. If `imem_rvalid_i` arrives the same cycle, drop it and go to REQ.
  - From DRAIN: update `pc_q` and stay DRAIN, unless rvalid arrives (then REQ).
- Stall during WAIT does not block response capture.
- Arithmetic: `+4` is modulo 2^WIDTH. `0xFFFF_FFFC` wraps to `0`.
- Instruction memory shares `reset` and abandons any outstanding request on reset. No stale response follows reset release.

## Timing
- Reset values:
  - `pc_q = RESET_PC`, `req_pc_q = 0`, state REQ
  - `instr_o = NOP_INSTR`, `pc_o = 0`, `pc4_o = 0`, `instr_valid_o = 0`
  - `imem_req_o = 0` while reset is asserted
- `imem_req_o` is combinational from state, valid, `stall_i`, `redirect_i`. `imem_addr_o = pc_q`.
- Memory latency is ≥1 cycle. rvalid is never in the same cycle as the request.
- Request cycle N with latency L: output valid from cycle N+L+1. The next request may fire in cycle N+L+1, giving a peak rate of one instruction per L+1 cycles.
- Outputs are fully registered. No combinational path from `imem_rdata_i` to `instr_o`.

## Structure
- Shared package `rv32i_pkg` holds:
  - `NOP_INSTR`
  - the `fetch_state_t` enum {REQ, WAIT, DRAIN}
  - the default `RESET_PC`
- Single module with no sub-modules. The FSM and output register are inline.

## Test plan
- **Reset release, 1-cycle memory (`mem[a] = 0xA000_0000 | a`):**
  - cycle 0 req addr 0
  - cycle 2 `instr_o = 0xA000_0000`, `pc_o = 0`, `pc4_o = 4`, valid=1
  - cycle 2 req addr 4
- **`stall_i` high for 3 cycles while valid:** outputs constant, `imem_req_o = 0`. Fetch resumes the cycle stall drops.
- **Redirect to 0x100 while WAIT for addr 8:**
  - response for 8 is dropped and never appears
  - next req addr 0x100
  - `instr_valid_o` stays 0 until the 0x100 data arrives
- **Redirect target 0x102 together with `stall_i = 1`:** redirect wins and the next req addr is 0x100.
- **Redirect and `imem_rvalid_i` in the same cycle:** data dropped, state REQ, req addr = target next cycle.
- **Reset asserted mid-WAIT:** outputs go immediately to NOP/0/0/0. First request after release is at `RESET_PC`. PC wrap check: fetch at 0xFFFF_FFFC gives `pc4_o = 0`, next req addr 0.
